// File: rtl/key_event_counter.sv
// Two-key debounced event counter: step/load keys drive a CNT_W-bit up/down counter
// with wrap or saturate, LED switch snapshot and per-nibble 7-segment outputs.

module key_event_counter_db #(
    parameter int DB_CYC = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic press_o
);
    // state    | meaning
    // RELEASED | debounced key is up; low level must persist DB_CYC cycles to flip
    // PRESSED  | debounced key is down; high level must persist DB_CYC cycles to flip

    localparam int CW = (DB_CYC < 2) ? 1 : $clog2(DB_CYC + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYC - 1);

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } db_state_e;

    db_state_e state_q, state_d;
    db_state_e prev_q, prev_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          level_pressed;

    assign sync_d        = {sync_q[0], key_n_i};
    assign level_pressed = ~sync_q[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            state_q <= RELEASED;
            prev_q  <= RELEASED;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (level_pressed != (state_q == PRESSED)) begin
            if (cnt_q == DB_LAST) begin
                state_d = (state_q == PRESSED) ? RELEASED : PRESSED;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // The pulse is taken from the registered state history, one cycle after the flip.
    always_comb begin
        prev_d  = state_q;
        press_d = (state_q == PRESSED) && (prev_q == RELEASED);
    end

    assign press_o = press_q;

endmodule

module key_event_counter #(
    parameter int CNT_W  = 8,
    parameter int SW_W   = 10,
    parameter int DB_CYC = 1000000
) (
    input  logic                     clk100_i,
    input  logic                     rst_i,
    input  logic [SW_W-1:0]          sw_i,
    input  logic [1:0]               key_i,
    output logic [SW_W-1:0]          ledr_o,
    output logic [7*(CNT_W/4)-1:0]   hex_o,
    output logic                     ovf_o
);
    localparam int ND = CNT_W / 4;
    localparam int LW = SW_W - 2;

    logic             step_p;
    logic             load_p;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW_W-1:0]  ledr_q, ledr_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W:0]   step_ext;
    logic [CNT_W:0]   sum;
    logic [CNT_W:0]   diff;
    logic             dir;
    logic             sat;

    key_event_counter_db #(.DB_CYC(DB_CYC)) u_db_step (
        .clk_i   (clk100_i),
        .rst_i   (rst_i),
        .key_n_i (key_i[0]),
        .press_o (step_p)
    );

    key_event_counter_db #(.DB_CYC(DB_CYC)) u_db_load (
        .clk_i   (clk100_i),
        .rst_i   (rst_i),
        .key_n_i (key_i[1]),
        .press_o (load_p)
    );

    assign dir      = sw_i[SW_W-1];
    assign sat      = sw_i[SW_W-2];
    assign step_ext = {{(CNT_W-3){1'b0}}, sw_i[3:0]};

    generate
        if (LW >= CNT_W) begin : g_load_trunc
            assign load_val = sw_i[CNT_W-1:0];
        end else begin : g_load_ext
            assign load_val = {{(CNT_W-LW){1'b0}}, sw_i[LW-1:0]};
        end
    endgenerate

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            ledr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ledr_q <= ledr_d;
            ovf_q  <= ovf_d;
        end
    end

    // Bit CNT_W of sum/diff is the carry or borrow out of the counter range.
    always_comb begin
        sum    = {1'b0, cnt_q} + step_ext;
        diff   = {1'b0, cnt_q} - step_ext;
        cnt_d  = cnt_q;
        ledr_d = ledr_q;
        ovf_d  = ovf_q;
        if (load_p) begin
            cnt_d  = load_val;
            ovf_d  = 1'b0;
            ledr_d = sw_i;
        end else if (step_p) begin
            ledr_d = sw_i;
            if (!dir) begin
                cnt_d = sum[CNT_W-1:0];
                if (sum[CNT_W]) begin
                    ovf_d = 1'b1;
                    if (sat) cnt_d = '1;
                end
            end else begin
                cnt_d = diff[CNT_W-1:0];
                if (diff[CNT_W]) begin
                    ovf_d = 1'b1;
                    if (sat) cnt_d = '0;
                end
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        hex_o = '1;
        for (int k = 0; k < ND; k++) begin
            hex_o[7*k +: 7] = seg7(cnt_q[4*k +: 4]);
        end
    end

    assign ledr_o = ledr_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_key_event_counter.sv
// Directed bench for key_event_counter with a cycle-level reference model of the
// debounce timing and counter arithmetic, checked on every negative clock edge.

module tb_key_event_counter;
    localparam int CNT_W  = 8;
    localparam int SW_W   = 10;
    localparam int DB_CYC = 4;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [SW_W-1:0] sw  = '0;
    logic [1:0]      key = 2'b11;
    logic [SW_W-1:0] ledr;
    logic [13:0]     hex;
    logic            ovf;

    int checks = 0;
    int errors = 0;

    key_event_counter #(.CNT_W(CNT_W), .SW_W(SW_W), .DB_CYC(DB_CYC)) dut (
        .clk100_i (clk),
        .rst_i    (rst),
        .sw_i     (sw),
        .key_i    (key),
        .ledr_o   (ledr),
        .hex_o    (hex),
        .ovf_o    (ovf)
    );

    always #5 clk = ~clk;

    // Reference model state
    int              m_cnt  = 0;
    logic [SW_W-1:0] m_ledr = '0;
    bit              m_ovf  = 1'b0;
    int              cyc    = 0;
    bit              dly1 [2] = '{1'b1, 1'b1};
    bit              dly2 [2] = '{1'b1, 1'b1};
    bit              down [2] = '{1'b0, 1'b0};
    int              run  [2] = '{0, 0};
    int              due  [2] = '{-1, -1};

    function automatic logic [13:0] hex_of(input int v);
        logic [13:0] h;
        h[6:0]  = GLYPH[v % 16];
        h[13:7] = GLYPH[(v / 16) % 16];
        return h;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_ledr = '0; m_ovf = 1'b0; cyc = 0;
        for (int k = 0; k < 2; k++) begin
            dly1[k] = 1'b1; dly2[k] = 1'b1; down[k] = 1'b0; run[k] = 0; due[k] = -1;
        end
    endtask

    // One clock edge of the specified behaviour: pending presses take effect two
    // edges after the debounced flip, then each key's delayed level is qualified.
    task automatic model_edge();
        int  s;
        int  r;
        bit  lvl;
        cyc++;
        if (due[1] == cyc) begin
            m_cnt  = int'(sw[SW_W-3:0]) % 256;
            m_ovf  = 1'b0;
            m_ledr = sw;
        end else if (due[0] == cyc) begin
            s = int'(sw[3:0]);
            r = sw[SW_W-1] ? m_cnt - s : m_cnt + s;
            if (r > 255) begin
                m_ovf = 1'b1;
                r = sw[SW_W-2] ? 255 : r - 256;
            end else if (r < 0) begin
                m_ovf = 1'b1;
                r = sw[SW_W-2] ? 0 : r + 256;
            end
            m_cnt  = r;
            m_ledr = sw;
        end
        for (int k = 0; k < 2; k++) begin
            lvl     = !dly2[k];
            dly2[k] = dly1[k];
            dly1[k] = key[k];
            if (lvl != down[k]) begin
                run[k]++;
                if (run[k] == DB_CYC) begin
                    down[k] = !down[k];
                    run[k]  = 0;
                    if (down[k]) due[k] = cyc + 2;
                end
            end else begin
                run[k] = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_edge();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_hex",  {18'd0, hex},  {18'd0, hex_of(m_cnt)});
            chk("model_ledr", {22'd0, ledr}, {22'd0, m_ledr});
            chk("model_ovf",  {31'd0, ovf},  {31'd0, m_ovf});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int k);
        key[k] = 1'b0;
        idle(12);
        key[k] = 1'b1;
        idle(12);
    endtask

    initial begin
        #1 rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);
        chk("rst_hex",  {18'd0, hex}, {18'd0, 7'h40, 7'h40});
        chk("rst_ledr", {22'd0, ledr}, 32'd0);
        chk("rst_ovf",  {31'd0, ovf}, 32'd0);

        key[0] = 1'b0;
        idle(3);
        key[0] = 1'b1;
        idle(15);
        chk("glitch_hex", {18'd0, hex}, {18'd0, 7'h40, 7'h40});

        sw = 10'b00_0000_0011;
        idle(1);
        key[0] = 1'b0;
        idle(7);
        chk("lat_before", {18'd0, hex}, {18'd0, 7'h40, 7'h40});
        idle(1);
        chk("lat_at7", {18'd0, hex}, {18'd0, 7'h40, 7'h30});
        idle(12);
        chk("held_once", {18'd0, hex}, {18'd0, 7'h40, 7'h30});
        chk("held_ledr", {22'd0, ledr}, 32'h003);
        key[0] = 1'b1;
        idle(12);
        repeat (3) press(0);
        chk("cnt_0c", {18'd0, hex}, {18'd0, 7'h40, 7'h46});

        sw = 10'b00_1111_1110; press(1);
        chk("load_fe", {18'd0, hex}, {18'd0, 7'h0E, 7'h06});
        sw = 10'b00_0000_0011; press(0);
        chk("wrap_up", {18'd0, hex}, {18'd0, 7'h40, 7'h79});
        chk("wrap_up_ovf", {31'd0, ovf}, 32'd1);
        sw = 10'b00_1111_1110; press(1);
        chk("reload_ovf", {31'd0, ovf}, 32'd0);
        sw = 10'b01_0000_0011; press(0);
        chk("sat_up", {18'd0, hex}, {18'd0, 7'h0E, 7'h0E});
        chk("sat_up_ovf", {31'd0, ovf}, 32'd1);

        sw = 10'b00_0000_0010; press(1);
        sw = 10'b11_0000_0101; press(0);
        chk("sat_dn", {18'd0, hex}, {18'd0, 7'h40, 7'h40});
        chk("sat_dn_ovf", {31'd0, ovf}, 32'd1);
        sw = 10'b00_0000_0010; press(1);
        sw = 10'b10_0000_0101; press(0);
        chk("wrap_dn", {18'd0, hex}, {18'd0, 7'h0E, 7'h21});
        chk("wrap_dn_ovf", {31'd0, ovf}, 32'd1);
        sw = 10'b00_1000_0000; press(0);
        chk("step0_hex", {18'd0, hex}, {18'd0, 7'h0E, 7'h21});
        chk("step0_ledr", {22'd0, ledr}, 32'h080);

        sw = 10'b00_0100_0010;
        key = 2'b00;
        idle(12);
        key = 2'b11;
        idle(12);
        chk("both_hex", {18'd0, hex}, {18'd0, 7'h19, 7'h24});
        chk("both_ovf", {31'd0, ovf}, 32'd0);
        chk("both_ledr", {22'd0, ledr}, 32'h042);

        key[0] = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(2);
        key[0] = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(20);
        chk("abort_hex", {18'd0, hex}, {18'd0, 7'h40, 7'h40});
        chk("abort_ledr", {22'd0, ledr}, 32'd0);
        sw = 10'b00_0000_0111; press(0);
        chk("after_abort", {18'd0, hex}, {18'd0, 7'h40, 7'h78});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
